muldiv_sched: RTL and testbench
===============================

// Module: muldiv_sched
// PURPOSE
//  Sequencer and HI/LO owner for the MIPS multiply/divide unit. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX stage.
//  It drives one shared unsigned iterative engine (the shift-add multiplier plus a restoring divider) through a start/done handshake.
//  Signed operations are handled here: operands are reduced to magnitudes on entry and the result sign is fixed on exit.
//  It stalls the pipeline while the engine is busy and aborts in-flight work when the pipeline is flushed.
// PARAMETERS
//  W  32  operand width; the product is 2W bits
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous reset, active-high
//  op_valid     in   1    EX stage presents an operation
//  op_code      in   3    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//  op_a, op_b   in   W    rs, rt values (MT* uses op_a only)
//  flush        in   1    pipeline flush; aborts the in-flight operation
//  stall        out  1    combinational: op_valid & (state != IDLE) & !flush
//  rd_data      out  W    MFHI/MFLO result, registered
//  rd_valid     out  1    one-cycle pulse; rd_data is valid in the same cycle
//  busy         out  1    state != IDLE
//  dbz          out  1    one-cycle pulse: DIV/DIVU with op_b == 0
//  eng_start    out  1    one-cycle pulse; operands held stable until eng_done
//  eng_abort    out  1    one-cycle pulse; engine returns to idle
//  eng_op       out  1    0 multiply, 1 divide
//  eng_a, eng_b out  W    unsigned magnitudes
//  eng_done     in   1    one-cycle pulse; eng_hi/eng_lo valid in the same cycle
//  eng_hi       in   W    multiply: product[2W-1:W]; divide: remainder
//  eng_lo       in   W    multiply: product[W-1:0]; divide: quotient
// BEHAVIOUR
//  - Reset: state IDLE; HI = LO = 0; rd_data = 0. All pulse outputs and eng_* outputs are 0.
//  - Async reset mid-operation wins at once: state goes to IDLE and HI/LO clear. Any later eng_done is ignored.
//  - An op is accepted when op_valid & !stall & !flush. If flush and op_valid are high together, flush wins and the op is dropped.
//  - States: IDLE -> ISSUE -> WAIT -> FIX -> IDLE.
//  - IDLE, MT*: HI or LO <= op_a at the edge. State stays IDLE; no stall.
//  - IDLE, MF*: rd_data <= HI or LO and rd_valid = 1 on the next cycle.
//  - MF* in the cycle right after an MT* returns the new value.
//  - IDLE, MULT/DIV and variants:
//      latch sa = op_a[W-1] & signed, sb = op_b[W-1] & signed;
//      latch mag_a = sa ? -op_a : op_a, and mag_b likewise;
//      then go to ISSUE.
//      -2^(W-1) gives magnitude 2^(W-1), which is unsigned-exact.
//  - DIV/DIVU with op_b == 0: no engine start. HI <= op_a, LO <= all ones, and dbz pulses next cycle. State stays IDLE.
//  - ISSUE: eng_start = 1 for one cycle, then go to WAIT.
//  - WAIT: hold; on eng_done, latch eng_hi/eng_lo and go to FIX. Another eng_done in IDLE is ignored.
//  - FIX, multiply: if sa^sb, {HI,LO} <= -{eng_hi,eng_lo} (2W-bit two's complement), else pass through.
//  - FIX, divide: LO <= (sa^sb) ? -q : q and HI <= sa ? -r : r.
//      DIV of -2^(W-1) by -1 wraps to LO = 0x80000000, HI = 0.
//  - FIX writes HI/LO and returns to IDLE.
//  - Latency: accept edge to HI/LO update = 3 + engine cycles. An MF* stalled behind the op is accepted the cycle FIX ends.
//  - flush in ISSUE or WAIT: eng_abort pulses, state goes to IDLE, HI/LO are unchanged.
//  - flush in FIX: the write still completes, because the instruction already retired from EX.
//  - flush in IDLE: no effect.
//  - eng_done in the same cycle as flush: flush wins and the result is discarded.
// TESTING
//  Bench engine model: fixed 16-cycle latency.
//  1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001 exactly 19 cycles after accept. eng_start seen once.
//  2. MULT -3 x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
//     MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0.
//  3. DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
//     DIVU 7 / 2 -> LO = 3, HI = 1.
//     DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
//  4. DIV 5 / 0 -> dbz pulse, no eng_start, HI = 5, LO = 0xFFFFFFFF, busy stays 0.
//  5. MULT then back-to-back MFLO -> stall high through FIX; rd_valid pulses once with the product low word.
//     MTHI 0x1234 then MFHI -> rd_data = 0x1234 with no stall.
//  6. flush in WAIT cycle 5 -> eng_abort pulses, HI/LO keep their old values, and the late eng_done is ignored.
//     Async rst in WAIT -> HI = LO = 0, busy = 0 before the next edge.

Source files
------------

// File: rtl/muldiv_sched.sv
`default_nettype none
// muldiv_sched (rev 1.0): HI/LO owner and sequencer for a shared unsigned iterative mul/div engine.
// Signed operands are reduced to magnitudes on entry, and the result sign is restored in FIX.
module muldiv_sched #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         busy,
  output logic         dbz,
  output logic         eng_start,
  output logic         eng_abort,
  output logic         eng_op,
  output logic [W-1:0] eng_a,
  output logic [W-1:0] eng_b,
  input  logic         eng_done,
  input  logic [W-1:0] eng_hi,
  input  logic [W-1:0] eng_lo
);

  localparam logic [2:0] c_OP_MTHI = 3'd4;
  localparam logic [2:0] c_OP_MTLO = 3'd5;
  localparam logic [2:0] c_OP_MFHI = 3'd6;
  localparam logic [2:0] c_OP_MFLO = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIX   = 2'd3
  } state_e;

  state_e         state_q;
  logic [W-1:0]   hi_q, lo_q;
  logic [W-1:0]   rd_data_q;
  logic [W-1:0]   mag_a_q, mag_b_q;
  logic [W-1:0]   res_hi_q, res_lo_q;
  logic           sa_q, sb_q, op_div_q;
  logic           rd_valid_q, dbz_q, eng_start_q, eng_abort_q;

  logic           accept;
  logic           sa_d, sb_d;
  logic [W-1:0]   mag_a_d, mag_b_d;
  logic [2*W-1:0] prod_raw, prod_fix;
  logic [W-1:0]   hi_d, lo_d;

  assign busy   = (state_q != S_IDLE);
  assign stall  = op_valid & busy & ~flush;
  assign accept = op_valid & ~busy & ~flush;

  // Only MULT (0) and DIV (2) are signed, so op_code[0] clear marks a signed op.
  always_comb begin
    sa_d    = op_a[W-1] & ~op_code[0];
    sb_d    = op_b[W-1] & ~op_code[0];
    mag_a_d = sa_d ? -op_a : op_a;
    mag_b_d = sb_d ? -op_b : op_b;
  end

  always_comb begin
    prod_raw = {res_hi_q, res_lo_q};
    prod_fix = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
    if (op_div_q) begin
      lo_d = (sa_q ^ sb_q) ? -res_lo_q : res_lo_q;
      hi_d = sa_q ? -res_hi_q : res_hi_q;
    end else begin
      hi_d = prod_fix[2*W-1:W];
      lo_d = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      rd_data_q   <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      op_div_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      dbz_q       <= 1'b0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      dbz_q       <= 1'b0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op_code)
              c_OP_MTHI: hi_q <= op_a;
              c_OP_MTLO: lo_q <= op_a;
              c_OP_MFHI: begin
                rd_data_q  <= hi_q;
                rd_valid_q <= 1'b1;
              end
              c_OP_MFLO: begin
                rd_data_q  <= lo_q;
                rd_valid_q <= 1'b1;
              end
              default: begin
                // Divide by zero never reaches the engine; results are fixed here.
                if (op_code[1] && (op_b == '0)) begin
                  hi_q  <= op_a;
                  lo_q  <= '1;
                  dbz_q <= 1'b1;
                end else begin
                  sa_q        <= sa_d;
                  sb_q        <= sb_d;
                  mag_a_q     <= mag_a_d;
                  mag_b_q     <= mag_b_d;
                  op_div_q    <= op_code[1];
                  eng_start_q <= 1'b1;
                  state_q     <= S_ISSUE;
                end
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (flush) begin
            eng_abort_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            eng_abort_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (eng_done) begin
            res_hi_q <= eng_hi;
            res_lo_q <= eng_lo;
            state_q  <= S_FIX;
          end
        end
        S_FIX: begin
          // The instruction has already retired, so a flush here cannot cancel the write.
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign dbz       = dbz_q;
  assign eng_start = eng_start_q;
  assign eng_abort = eng_abort_q;
  assign eng_op    = op_div_q;
  assign eng_a     = mag_a_q;
  assign eng_b     = mag_b_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// tb_muldiv_sched: vector table plus directed multi-cycle sequences against a 16-cycle unsigned engine model.
module tb_muldiv_sched;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, rd_valid, busy, dbz, eng_start, eng_abort, eng_op, eng_done;
  logic [31:0] rd_data, eng_a, eng_b, eng_hi, eng_lo;

  always #5 clk = ~clk;

  muldiv_sched #(.W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .dbz(dbz),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_op(eng_op),
    .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
    .eng_hi(eng_hi), .eng_lo(eng_lo)
  );

  // Ideal unsigned engine: done pulses 16 cycles after it samples start.
  logic        m_act, m_op;
  int          m_cnt;
  logic [31:0] m_a, m_b;
  logic [63:0] m_prod;
  logic        man_done;
  logic [31:0] man_hi, man_lo;
  int          start_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_cnt <= 0; m_op <= 1'b0; m_a <= '0; m_b <= '0; start_cnt <= 0;
    end else begin
      if (eng_start) start_cnt <= start_cnt + 1;
      if (eng_abort) m_act <= 1'b0;
      else if (eng_start) begin
        m_act <= 1'b1; m_cnt <= 16; m_op <= eng_op; m_a <= eng_a; m_b <= eng_b;
      end else if (m_act) begin
        if (m_cnt == 0) m_act <= 1'b0;
        else m_cnt <= m_cnt - 1;
      end
    end
  end

  assign m_prod   = {32'd0, m_a} * {32'd0, m_b};
  assign eng_done = (m_act && m_cnt == 0) || man_done;
  assign eng_hi   = man_done ? man_hi : (m_op ? ((m_b == 0) ? 32'd0 : m_a % m_b) : m_prod[63:32]);
  assign eng_lo   = man_done ? man_lo : (m_op ? ((m_b == 0) ? 32'd0 : m_a / m_b) : m_prod[31:0]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic dbz_seen);
    @(negedge clk); op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(negedge clk); op_valid = 1'b0;
    dbz_seen = dbz;
    lat = 0;
    while (busy && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic read_reg(input string name, input logic [2:0] c, input logic [31:0] exp);
    @(negedge clk); op_valid = 1'b1; op_code = c; op_a = '0; op_b = '0;
    @(negedge clk); op_valid = 1'b0;
    chk({name, " rd_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(name, rd_data, exp);
  endtask

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s0, k, rdv;
    logic dz;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[6]  = '{DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{MULT,  32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};
    vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
    vecs[11] = '{DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b1};

    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; flush = 1'b0;
    man_done = 1'b0; man_hi = '0; man_lo = '0;
    #23;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset pulses", {28'd0, rd_valid, dbz, eng_start, eng_abort}, 32'd0);
    chk("reset eng_op", {31'd0, eng_op}, 32'd0);
    chk("reset eng_a", eng_a, 32'd0);
    chk("reset eng_b", eng_b, 32'd0);
    @(negedge clk); rst = 1'b0;
    read_reg("reset HI", MFHI, 32'd0);
    read_reg("reset LO", MFLO, 32'd0);

    for (int i = 0; i < 12; i++) begin
      s0 = start_cnt;
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, lat, dz);
      chk($sformatf("v%0d latency", i), lat, vecs[i].dbz ? 32'd0 : 32'd19);
      chk($sformatf("v%0d dbz", i), {31'd0, dz}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d starts", i), start_cnt - s0, vecs[i].dbz ? 32'd0 : 32'd1);
      read_reg($sformatf("v%0d HI", i), MFHI, vecs[i].hi);
      read_reg($sformatf("v%0d LO", i), MFLO, vecs[i].lo);
    end

    // MULT followed immediately by MFLO: MFLO stalls through FIX then returns the new low word.
    @(negedge clk); op_valid = 1'b1; op_code = MULT; op_a = 32'd6; op_b = 32'hFFFFFFFE;
    @(negedge clk); op_code = MFLO; op_a = '0; op_b = '0; #1;
    k = 0; rdv = 0;
    while (stall && k < 100) begin
      k++;
      if (rd_valid) rdv++;
      @(negedge clk); #1;
    end
    chk("mflo stall cycles", k, 32'd19);
    @(negedge clk); op_valid = 1'b0;
    chk("mflo rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("mflo rd_data", rd_data, 32'hFFFFFFF4);
    if (rd_valid) rdv++;
    @(negedge clk);
    if (rd_valid) rdv++;
    chk("mflo rd_valid pulses", rdv, 32'd1);

    // MTHI then MFHI back to back.
    @(negedge clk); op_valid = 1'b1; op_code = MTHI; op_a = 32'h1234; #1;
    chk("mthi stall", {31'd0, stall}, 32'd0);
    @(negedge clk); op_code = MFHI; op_a = '0; #1;
    chk("mfhi stall", {31'd0, stall}, 32'd0);
    @(negedge clk); op_valid = 1'b0;
    chk("mfhi rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("mfhi rd_data", rd_data, 32'h1234);

    // Flush in WAIT cycle 5, then a stray eng_done while idle.
    s0 = start_cnt;
    @(negedge clk); op_valid = 1'b1; op_code = MULTU; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk); op_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("wait busy before flush", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("wait flush eng_abort", {31'd0, eng_abort}, 32'd1);
    chk("wait flush busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("wait flush abort pulse", {31'd0, eng_abort}, 32'd0);
    man_done = 1'b1; man_hi = 32'hAAAA5555; man_lo = 32'h5555AAAA;
    @(negedge clk); man_done = 1'b0;
    chk("late done busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("flush starts", start_cnt - s0, 32'd1);
    read_reg("flush HI kept", MFHI, 32'h1234);
    read_reg("flush LO kept", MFLO, 32'hFFFFFFF4);

    // Flush together with op_valid in IDLE drops the op.
    @(negedge clk); op_valid = 1'b1; op_code = MTLO; op_a = 32'hDEAD; flush = 1'b1;
    @(negedge clk); op_valid = 1'b0; flush = 1'b0;
    read_reg("idle flush LO", MFLO, 32'hFFFFFFF4);

    // Flush during FIX does not cancel the write.
    @(negedge clk); op_valid = 1'b1; op_code = MULTU; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk); op_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("fix busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("fix flush eng_abort", {31'd0, eng_abort}, 32'd0);
    chk("fix flush busy", {31'd0, busy}, 32'd0);
    read_reg("fix flush HI", MFHI, 32'd0);
    read_reg("fix flush LO", MFLO, 32'd6);

    // eng_done coinciding with flush: result discarded.
    @(negedge clk); op_valid = 1'b1; op_code = MULTU; op_a = 32'd7; op_b = 32'd7;
    @(negedge clk); op_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("done+flush engine done", {31'd0, eng_done}, 32'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("done+flush eng_abort", {31'd0, eng_abort}, 32'd1);
    chk("done+flush busy", {31'd0, busy}, 32'd0);
    read_reg("done+flush LO", MFLO, 32'd6);

    // Asynchronous reset in WAIT.
    @(negedge clk); op_valid = 1'b1; op_code = MULTU; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk); op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst wait busy before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst eng_a", eng_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    read_reg("async rst HI", MFHI, 32'd0);
    read_reg("async rst LO", MFLO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
